// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// bit-counter width helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counter must index 0..WIDTH-1; keep at least one bit for tiny widths.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Full-adder cell built from two half-adder cells and an OR gate; used as the
// per-bit datapath of the serial adder.
module half_adder (
    input  logic x,
    input  logic y,
    output logic c,
    output logic s
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic cout,
    output logic s
);
    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (.x(x),  .y(y),   .c(c0), .s(s0));
    half_adder u_ha1 (.x(s0), .y(cin), .c(c1), .s(s));

    // Both half-adder carries can never be high together, so OR is exact.
    assign cout = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus carry flop, LSB first, with a
// start/busy/done handshake and registered sum/cout that update on completion.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-2:0] sum_sr_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] sum_d;

    full_adder u_fa (
        .x    (a_sr_q[0]),
        .y    (b_sr_q[0]),
        .cin  (carry_q),
        .cout (fa_c),
        .s    (fa_s)
    );

    // The partial-sum register holds only WIDTH-1 bits: on the last bit the
    // fresh sum bit completes the word without an extra shift.
    assign sum_d = {fa_s, sum_sr_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sr_q  <= a;
                        b_sr_q  <= b;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sr_q   <= a_sr_q >> 1;
                    b_sr_q   <= b_sr_q >> 1;
                    sum_sr_q <= sum_d[WIDTH-1:1];
                    carry_q  <= fa_c;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        sum_q   <= sum_d;
                        cout_q  <= fa_c;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sr_q  <= a;
                        b_sr_q  <= b;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) with a result scoreboard,
// plus an exhaustive check of the full_adder cell.
module tb_serial_adder;
    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    logic fa_x, fa_y, fa_cin, fa_cout, fa_s;

    int checks   = 0;
    int failures = 0;

    logic [W:0] sb_q[$];
    logic [W-1:0] prev_sum;
    logic         prev_cout;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    full_adder u_fa (
        .x    (fa_x),
        .y    (fa_y),
        .cin  (fa_cin),
        .cout (fa_cout),
        .s    (fa_s)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest pushed result.
    always @(negedge clk) begin
        if (!rst && done) begin
            logic [W:0] e;
            check("busy_with_done", 32'(busy), 32'd0);
            if (sb_q.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("sum", 32'(sum), 32'(e[W-1:0]));
                check("cout", 32'(cout), 32'(e[W]));
                $display("done: sum=%02h cout=%0d (exp %02h/%0d)", sum, cout, e[W-1:0], e[W]);
            end
        end
    end

    task automatic push_exp(input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [W:0] full;
        full = {1'b0, av} + {1'b0, bv};
        sb_q.push_back(full);
    endtask

    // Wait for the done pulse; lat counts negedges from the call.
    task automatic wait_done(output int lat, output int busy_n);
        lat = 0;
        busy_n = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (busy) busy_n++;
            if (done) return;
        end
        check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic add_op(input logic [W-1:0] av, input logic [W-1:0] bv);
        int lat;
        int busy_n;
        logic [W:0] full;
        full = {1'b0, av} + {1'b0, bv};
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        push_exp(av, bv);
        $display("start: a=%02h b=%02h", av, bv);
        @(negedge clk);
        start = 1'b0;
        check("hold_sum", 32'(sum), 32'(prev_sum));
        check("hold_cout", 32'(cout), 32'(prev_cout));
        check("busy_run", 32'(busy), 32'd1);
        a = ~av;
        b = ~bv;
        wait_done(lat, busy_n);
        check("latency", 32'(lat + 1), 32'd9);
        check("busy_cycles", 32'(busy_n + 1), 32'd8);
        prev_sum  = full[W-1:0];
        prev_cout = full[W];
    endtask

    initial begin
        int lat;
        int busy_n;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        fa_x = 1'b0; fa_y = 1'b0; fa_cin = 1'b0;
        prev_sum = '0;
        prev_cout = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        rst = 1'b0;

        add_op(8'h00, 8'h00);
        add_op(8'h01, 8'h01);
        add_op(8'hA5, 8'h5A);
        add_op(8'hFF, 8'h01);
        add_op(8'hFF, 8'hFF);

        // Start during RUN is ignored; start in DONE chains with no IDLE cycle.
        @(negedge clk);
        a = 8'h10; b = 8'h20; start = 1'b1;
        push_exp(8'h10, 8'h20);
        $display("start: a=10 b=20 (then ignored FF+FF)");
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, busy_n);
        a = 8'h11; b = 8'h22; start = 1'b1;
        push_exp(8'h11, 8'h22);
        $display("start: a=11 b=22 (back-to-back)");
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_done", 32'(done), 32'd0);
        wait_done(lat, busy_n);
        check("b2b_latency", 32'(lat + 1), 32'd9);
        prev_sum = 8'h33;
        prev_cout = 1'b0;

        // Asynchronous reset mid-operation discards the partial result.
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #10 rst = 1'b1;
        #1;
        $display("async reset mid-run");
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_sum", 32'(sum), 32'd0);
        check("arst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        prev_sum = '0;
        prev_cout = 1'b0;
        add_op(8'h03, 8'h04);
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            logic [1:0] e2;
            v = 3'(i);
            fa_x = v[0]; fa_y = v[1]; fa_cin = v[2];
            #1;
            e2 = 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
            $display("full_adder: x=%0d y=%0d cin=%0d -> cout=%0d s=%0d", v[0], v[1], v[2], fa_cout, fa_s);
            check("fa_s", 32'(fa_s), 32'(e2[0]));
            check("fa_cout", 32'(fa_cout), 32'(e2[1]));
        end

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
